// File: rtl/airlock_pkg.sv
// Shared state encodings and default sizing for the airlock sequencer.
package airlock_pkg;

   localparam int unsigned DWELL_DEF   = 4;
   localparam int unsigned TIMEOUT_DEF = 16;
   localparam int unsigned CW_DEF      = 5;

   typedef enum logic [2:0] {
      P_IDLE  = 3'b000,
      D_START = 3'b001,
      D_WAIT  = 3'b010,
      V_IDLE  = 3'b011,
      P_START = 3'b100,
      P_WAIT  = 3'b101,
      FAULT   = 3'b111
   } state_e;

endpackage

// File: rtl/airlock_timer.sv
// Loadable saturating down-counter, shared between the door dwell and the done-pulse timeout.
module airlock_timer #(
   parameter int unsigned CW      = 5,
   parameter int unsigned RST_VAL = 4
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          zero
);

   logic [CW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         cnt_q <= CW'(RST_VAL);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/airlock_seq.sv
// Airlock sequencer: drives the pressurize/depressurize go/done handshake and door enables.
// Define AIRLOCK_TIMEOUT_EN to fault when a done pulse does not arrive within TIMEOUT cycles.
module airlock_seq
   import airlock_pkg::*;
#(
   parameter int unsigned DWELL   = DWELL_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned CW      = CW_DEF
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       req_vac,
   input  logic       req_press,
   input  logic       pressurized,
   input  logic       depressurized,
   output logic       press_go,
   output logic       depress_go,
   output logic       inner_door_en,
   output logic       outer_door_en,
   output logic       busy,
   output logic       fault,
   output logic [2:0] state_o
);

   state_e        state_d, state_q;
   logic          tmr_load;
   logic [CW-1:0] tmr_val;
   logic          tmr_dec;
   logic          tmr_zero;

   airlock_timer #(
      .CW      (CW),
      .RST_VAL (DWELL)
   ) u_timer (
      .Clock    (Clock),
      .Reset    (Reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= P_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = CW'(DWELL);
      tmr_dec  = 1'b0;
      case (state_q)
         P_IDLE: begin
            if (tmr_zero && req_vac) begin
               state_d = D_START;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         D_START: begin
            tmr_load = 1'b1;
            tmr_val  = CW'(TIMEOUT);
            state_d  = D_WAIT;
         end
         D_WAIT: begin
            // A done pulse on the expiry cycle still completes normally.
            if (depressurized) begin
               tmr_load = 1'b1;
               state_d  = V_IDLE;
            end
`ifdef AIRLOCK_TIMEOUT_EN
            else if (tmr_zero) begin
               state_d = FAULT;
            end else begin
               tmr_dec = 1'b1;
            end
`endif
         end
         V_IDLE: begin
            if (tmr_zero && req_press) begin
               state_d = P_START;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         P_START: begin
            tmr_load = 1'b1;
            tmr_val  = CW'(TIMEOUT);
            state_d  = P_WAIT;
         end
         P_WAIT: begin
            if (pressurized) begin
               tmr_load = 1'b1;
               state_d  = P_IDLE;
            end
`ifdef AIRLOCK_TIMEOUT_EN
            else if (tmr_zero) begin
               state_d = FAULT;
            end else begin
               tmr_dec = 1'b1;
            end
`endif
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            tmr_load = 1'b1;
            state_d  = P_IDLE;
         end
      endcase
   end

   // Every output decodes from the registered state, so doors can never overlap.
   always_comb begin
      inner_door_en = (state_q == P_IDLE);
      outer_door_en = (state_q == V_IDLE);
      press_go      = (state_q == P_START);
      depress_go    = (state_q == D_START);
      busy          = (state_q == D_START) || (state_q == D_WAIT) ||
                      (state_q == P_START) || (state_q == P_WAIT);
`ifdef AIRLOCK_TIMEOUT_EN
      fault         = (state_q == FAULT);
`else
      fault         = 1'b0;
`endif
      state_o       = state_q;
   end

endmodule

// File: tb/tb_airlock_seq.sv
// Directed and model-checked random bench for airlock_seq (default DWELL=4, TIMEOUT=16).
module tb_airlock_seq;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       req_vac = 1'b0;
   logic       req_press = 1'b0;
   logic       pressurized = 1'b0;
   logic       depressurized = 1'b0;
   logic       press_go, depress_go, inner_door_en, outer_door_en, busy, fault;
   logic [2:0] state_o;

   int total = 0;
   int bad   = 0;

   always #5 Clock = ~Clock;

   airlock_seq dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .req_vac       (req_vac),
      .req_press     (req_press),
      .pressurized   (pressurized),
      .depressurized (depressurized),
      .press_go      (press_go),
      .depress_go    (depress_go),
      .inner_door_en (inner_door_en),
      .outer_door_en (outer_door_en),
      .busy          (busy),
      .fault         (fault),
      .state_o       (state_o)
   );

   always @(negedge Clock) begin
      assert (!(inner_door_en && outer_door_en)) else $error("doors enabled together");
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "bench stalled");
   end

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset;
      Reset = 1'b0;
      tick();
      tick();
      total++;
      if (state_o !== 3'b000) begin
         bad++;
         $display("FAIL reset_state: got %b want 000", state_o);
      end
      total++;
      if ({inner_door_en, outer_door_en, press_go, depress_go, busy, fault} !== 6'b100000) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 100000",
                  {inner_door_en, outer_door_en, press_go, depress_go, busy, fault});
      end
   endtask

   // Leaves the DUT in D_WAIT at cycle 6, depress_go having pulsed in cycle 5.
   task automatic test_depress_request;
      Reset   = 1'b1;
      req_vac = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         total++;
         if (depress_go !== (c == 5)) begin
            bad++;
            $display("FAIL depress_go_c%0d: got %b want %b", c, depress_go, (c == 5));
         end
      end
      total++;
      if ({busy, state_o} !== 4'b1001) begin
         bad++;
         $display("FAIL d_start: got busy=%b state=%b want busy=1 state=001", busy, state_o);
      end
      tick();
      req_vac = 1'b0;
      total++;
      if ({state_o, depress_go, inner_door_en, outer_door_en} !== 6'b010000) begin
         bad++;
         $display("FAIL d_wait_entry: got state=%b go=%b doors=%b%b want 010 0 00",
                  state_o, depress_go, inner_door_en, outer_door_en);
      end
   endtask

   task automatic test_wrong_done;
      pressurized = 1'b1;
      tick();
      pressurized = 1'b0;
      total++;
      if ({state_o, inner_door_en, outer_door_en} !== 5'b01000) begin
         bad++;
         $display("FAIL wrong_done_dwait: got state=%b doors=%b%b want 010 00",
                  state_o, inner_door_en, outer_door_en);
      end
   endtask

   // Enters at cycle 7; depressurized arrives in cycle 13 (8 after depress_go).
   task automatic test_press_cycle;
      for (int c = 8; c <= 13; c++) tick();
      depressurized = 1'b1;
      req_press     = 1'b1;
      tick();
      depressurized = 1'b0;
      total++;
      if ({state_o, inner_door_en, outer_door_en, busy} !== 6'b011010) begin
         bad++;
         $display("FAIL v_idle_entry: got state=%b in=%b out=%b busy=%b want 011 0 1 0",
                  state_o, inner_door_en, outer_door_en, busy);
      end
      for (int c = 15; c <= 19; c++) begin
         tick();
         total++;
         if (press_go !== (c == 19)) begin
            bad++;
            $display("FAIL press_go_c%0d: got %b want %b", c, press_go, (c == 19));
         end
      end
      total++;
      if (state_o !== 3'b100) begin
         bad++;
         $display("FAIL p_start: got %b want 100", state_o);
      end
      tick();
      req_press = 1'b0;
      total++;
      if ({state_o, press_go} !== 4'b1010) begin
         bad++;
         $display("FAIL p_wait_entry: got state=%b go=%b want 101 0", state_o, press_go);
      end
      depressurized = 1'b1;
      tick();
      depressurized = 1'b0;
      total++;
      if (state_o !== 3'b101) begin
         bad++;
         $display("FAIL wrong_done_pwait: got %b want 101", state_o);
      end
   endtask

   // Reset in P_WAIT, stale pressurized pulse next, then a fresh full dwell.
   task automatic test_reset_in_wait;
      Reset = 1'b0;
      tick();
      total++;
      if ({state_o, inner_door_en} !== 4'b0001) begin
         bad++;
         $display("FAIL reset_in_wait: got state=%b in=%b want 000 1", state_o, inner_door_en);
      end
      Reset       = 1'b1;
      pressurized = 1'b1;
      req_vac     = 1'b1;
      req_press   = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         pressurized = 1'b0;
         if (c == 1) begin
            total++;
            if ({state_o, press_go} !== 4'b0000) begin
               bad++;
               $display("FAIL stale_done: got state=%b pgo=%b want 000 0", state_o, press_go);
            end
         end
         total++;
         if (depress_go !== (c == 5)) begin
            bad++;
            $display("FAIL reload_dwell_c%0d: got %b want %b", c, depress_go, (c == 5));
         end
      end
      req_vac   = 1'b0;
      req_press = 1'b0;
   endtask

`ifdef AIRLOCK_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      Reset = 1'b0;
      tick();
      Reset   = 1'b1;
      req_vac = 1'b1;
      n = 0;
      while (!depress_go && n < 20) begin
         tick();
         n++;
      end
      req_vac = 1'b0;
      total++;
      if (depress_go !== 1'b1) begin
         bad++;
         $display("FAIL to_go_wait: got %b want 1", depress_go);
      end
      for (int c = 1; c <= 17; c++) tick();
      total++;
      if (fault !== 1'b0) begin
         bad++;
         $display("FAIL to_early: got %b want 0", fault);
      end
      tick();
      total++;
      if ({fault, state_o, inner_door_en, outer_door_en} !== 6'b111100) begin
         bad++;
         $display("FAIL to_fault: got f=%b state=%b doors=%b%b want 1 111 00",
                  fault, state_o, inner_door_en, outer_door_en);
      end
      pressurized   = 1'b1;
      depressurized = 1'b1;
      tick();
      pressurized   = 1'b0;
      depressurized = 1'b0;
      total++;
      if ({fault, state_o, press_go, depress_go} !== 6'b111100) begin
         bad++;
         $display("FAIL to_sticky: got f=%b state=%b want 1 111", fault, state_o);
      end
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      total++;
      if ({fault, state_o} !== 4'b0000) begin
         bad++;
         $display("FAIL to_reset: got f=%b state=%b want 0 000", fault, state_o);
      end
      req_vac = 1'b1;
      n = 0;
      while (!depress_go && n < 20) begin
         tick();
         n++;
      end
      req_vac = 1'b0;
      for (int c = 1; c <= 17; c++) tick();
      depressurized = 1'b1;
      tick();
      depressurized = 1'b0;
      total++;
      if ({fault, state_o} !== 4'b0011) begin
         bad++;
         $display("FAIL to_done_wins: got f=%b state=%b want 0 011", fault, state_o);
      end
   endtask
`endif

   task automatic test_random;
      logic [2:0] m_st, n_st;
      int         m_cnt, n_cnt;
      logic       prev_pg, prev_dg;
      logic [5:0] exp_o;
      Reset = 1'b0;
      tick();
      Reset   = 1'b1;
      m_st    = 3'b000;
      m_cnt   = 4;
      prev_pg = 1'b0;
      prev_dg = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(3) == 0) req_vac = ~req_vac;
         if ($urandom_range(3) == 0) req_press = ~req_press;
         pressurized   = ($urandom_range(5) == 0);
         depressurized = ($urandom_range(5) == 0);
         n_st  = m_st;
         n_cnt = m_cnt;
         case (m_st)
            3'b000: if (m_cnt == 0 && req_vac) n_st = 3'b001;
                    else if (m_cnt > 0) n_cnt = m_cnt - 1;
            3'b001: begin n_st = 3'b010; n_cnt = 16; end
            3'b010: if (depressurized) begin n_st = 3'b011; n_cnt = 4; end
`ifdef AIRLOCK_TIMEOUT_EN
                    else if (m_cnt == 0) n_st = 3'b111;
                    else n_cnt = m_cnt - 1;
`endif
            3'b011: if (m_cnt == 0 && req_press) n_st = 3'b100;
                    else if (m_cnt > 0) n_cnt = m_cnt - 1;
            3'b100: begin n_st = 3'b101; n_cnt = 16; end
            3'b101: if (pressurized) begin n_st = 3'b000; n_cnt = 4; end
`ifdef AIRLOCK_TIMEOUT_EN
                    else if (m_cnt == 0) n_st = 3'b111;
                    else n_cnt = m_cnt - 1;
`endif
            default: n_st = m_st;
         endcase
         tick();
         m_st  = n_st;
         m_cnt = n_cnt;
         exp_o = {m_st == 3'b000, m_st == 3'b011, m_st == 3'b100, m_st == 3'b001,
                  m_st == 3'b001 || m_st == 3'b010 || m_st == 3'b100 || m_st == 3'b101,
                  m_st == 3'b111};
         total++;
         if (state_o !== m_st) begin
            bad++;
            $display("FAIL rand_state_%0d: got %b want %b", i, state_o, m_st);
         end
         total++;
         if ({inner_door_en, outer_door_en, press_go, depress_go, busy, fault} !== exp_o) begin
            bad++;
            $display("FAIL rand_outputs_%0d: got %b want %b", i,
                     {inner_door_en, outer_door_en, press_go, depress_go, busy, fault}, exp_o);
         end
         total++;
         if ((prev_pg && press_go) || (prev_dg && depress_go) ||
             (inner_door_en && outer_door_en)) begin
            bad++;
            $display("FAIL rand_pulse_doors_%0d: got pg=%b dg=%b in=%b out=%b want single pulse",
                     i, press_go, depress_go, inner_door_en, outer_door_en);
         end
         prev_pg = press_go;
         prev_dg = depress_go;
      end
      pressurized   = 1'b0;
      depressurized = 1'b0;
   endtask

   initial begin
      test_reset();
      test_depress_request();
      test_wrong_done();
      test_press_cycle();
      test_reset_in_wait();
`ifdef AIRLOCK_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
